data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU's memory-stage data port. It decodes each access from the pipeline (write strobe, byte address, write data, byte-lane select) and serves it from a word-organised data RAM or from a small memory-mapped register block (LED output, switch input, free-running timer with compare interrupt). It sits outside the core, directly on the core's data-memory pins, and returns read data in the same cycle the address is presented.

## Interface
Parameters:
- RAM_AW, 10, word-address width of the data RAM (2^RAM_AW words; default 4 KiB)
- MMIO_BASE, 16'hBFAF, value of addr[31:16] that selects the register block

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- memwrite  input  1  write strobe from the memory stage
- addr  input  32  byte address (aluout of the memory stage)
- wdata  input  32  write data, already lane-aligned by the core
- sel  input  4  byte-lane enables; sel[i] covers wdata[8i+7:8i]
- rdata  output  32  full aligned word at addr[31:2]
- sw  input  16  board switch levels
- led  output  16  LED register
- irq  output  1  timer-match interrupt level

## Operation
- Decode, in priority order:
  - addr[31:16]==MMIO_BASE → register block, offset addr[7:2]
  - addr[31:RAM_AW+2]==0 → RAM, index addr[RAM_AW+1:2]
  - otherwise unmapped: reads return 0, writes are dropped
- addr[1:0] is ignored; the core performs sub-word extraction and sign extension.
- RAM:
  - Writes are per byte lane: lane i is written only if memwrite && sel[i].
  - Reads are combinational.
  - RAM contents are not reset.
- Register block (word offsets):
  - 0x00 LED: R/W, bits [15:0]; reads zero-extended; byte-lane writes honoured.
  - 0x04 SWITCH: RO, {16'h0, sw}, sampled through a 2-flop synchroniser; writes ignored.
  - 0x08 TIMER: R/W, 32-bit. Increments by 1 every cycle with wrap 32'hFFFF_FFFF→0. A write loads the selected bytes, and no increment occurs in that cycle.
  - 0x0C COMPARE: R/W, 32-bit, byte-lane writes.
  - 0x10 STATUS: bit0 = match flag; other bits read 0. Writing 1 to bit0 with sel[0] set clears the flag.
  - Other offsets: read 0, writes ignored.
- Match: the flag sets on the edge where the next TIMER value equals COMPARE and COMPARE≠0.
  - If set and clear occur in the same cycle, set wins.
  - irq = match flag, registered output.
- Reads and writes never stall; there is no handshake.
  - Every cycle with memwrite=1 is a committed write.
  - Every other cycle is a side-effect-free read.

## Timing
- Read latency 0: rdata is valid combinationally in the same cycle as addr.
- Write commit: at the rising edge that ends the cycle in which memwrite=1.
  - A read in that same cycle returns the pre-write value.
  - The next cycle returns the new value.
- TIMER read value is the current register, i.e. the value before this cycle's increment.
- irq rises in the cycle after the edge on which TIMER becomes equal to COMPARE.
- Reset values (asynchronous, immediate on rst=1): led=0, TIMER=0, COMPARE=0, flag=0, irq=0, synchroniser flops=0.
  - rdata for register addresses reflects these values; for RAM addresses it reflects the unchanged array.
- Reset mid-write: a write in a cycle where rst is asserted is discarded for registers. For RAM, the write is blocked while rst=1.
- SWITCH latency: a change on sw is visible in rdata 2 cycles later.

## Test plan
- RAM byte lanes: write 32'h1122_3344 at 0x0000_0010 with sel=4'hF, then write 32'hAA00_0000 with sel=4'h8 → read at 0x10 returns 32'hAA22_3344; read of 0x13 returns the same word.
- Same-cycle read-after-write: present a write of 32'hDEAD_BEEF at 0x20 → rdata that cycle = old value; next cycle = 32'hDEAD_BEEF.
- Decode: write 0x5 at 32'h0000_1000 (RAM_AW=10, unmapped) → read returns 0 and RAM word 0 is unchanged. Write LED at 32'hBFAF_0000 with 32'h0001_A5A5 → led=16'hA5A5 and readback = 32'h0000_A5A5.
- Timer/compare:
  - write COMPARE=10, then TIMER=5 → irq rises exactly 6 cycles after the TIMER write edge.
  - write STATUS=1 → irq=0 the next cycle.
  - With COMPARE=0 → irq never asserts across a TIMER wrap from 32'hFFFF_FFFE.
- Set/clear collision: arrange a STATUS clear in the same cycle the match occurs → flag remains 1.
- Async reset: pulse rst between clock edges while led=16'hFFFF and TIMER≠0 → led, TIMER and irq read 0 immediately. A preloaded RAM word is still readable after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Serves the core's memory-stage data port from a word-organised data RAM or
// from a small register block (LED, switches, free-running timer with compare
// interrupt). Read data is combinational; writes commit on the rising edge
// that ends the cycle in which memwrite is high.
module data_mem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  output logic [31:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        irq
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  // Word offsets inside the register block (addr[7:2]).
  typedef enum logic [5:0] {
    REG_LED     = 6'd0,
    REG_SWITCH  = 6'd1,
    REG_TIMER   = 6'd2,
    REG_COMPARE = 6'd3,
    REG_STATUS  = 6'd4
  } reg_off_e;

  // Replace the bytes of old_word whose lane enable is set with new_word.
  function automatic logic [31:0] f_merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] r_ram [RAM_WORDS];
  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic [31:0] r_compare;
  logic        r_match;
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;

  // ---------------------------------------------------------------------------
  // Address decode: register block has priority over RAM; anything else is
  // unmapped (reads 0, writes dropped). addr[1:0] never matters because the
  // core does its own sub-word extraction.
  // ---------------------------------------------------------------------------
  logic              w_is_mmio;
  logic              w_is_ram;
  logic [RAM_AW-1:0] w_ram_idx;
  reg_off_e          w_reg_off;
  logic              w_unused;

  assign w_is_mmio = (addr[31:16] == MMIO_BASE);
  assign w_is_ram  = !w_is_mmio && (addr[31:RAM_AW+2] == '0);
  assign w_ram_idx = addr[RAM_AW+1:2];
  assign w_reg_off = reg_off_e'(addr[7:2]);
  assign w_unused  = &{1'b0, addr[15:8], addr[1:0]};

  // Per-target write strobes.
  logic w_ram_we;
  logic w_reg_we;
  logic w_led_we;
  logic w_timer_we;
  logic w_compare_we;
  logic w_status_we;

  assign w_ram_we     = memwrite && w_is_ram;
  assign w_reg_we     = memwrite && w_is_mmio;
  assign w_led_we     = w_reg_we && (w_reg_off == REG_LED);
  assign w_timer_we   = w_reg_we && (w_reg_off == REG_TIMER);
  assign w_compare_we = w_reg_we && (w_reg_off == REG_COMPARE);
  assign w_status_we  = w_reg_we && (w_reg_off == REG_STATUS);

  // ---------------------------------------------------------------------------
  // Timer and match detection. A timer write replaces the increment for that
  // cycle. The match compares the value the timer is about to take against
  // the current COMPARE; COMPARE==0 disables matching altogether.
  // ---------------------------------------------------------------------------
  logic [31:0] w_timer_next;
  logic        w_match_set;
  logic        w_match_clr;

  assign w_timer_next = w_timer_we ? f_merge_bytes(r_timer, wdata, sel)
                                   : r_timer + 32'd1;
  assign w_match_set  = (w_timer_next == r_compare) && (r_compare != 32'd0);
  assign w_match_clr  = w_status_we && sel[0] && wdata[0];

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Two-flop synchroniser for the asynchronous switch inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // LED register, byte-lane writable on its low two lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_led_we) begin
      if (sel[0]) r_led[7:0]  <= wdata[7:0];
      if (sel[1]) r_led[15:8] <= wdata[15:8];
    end
  end

  // Free-running timer; a write loads the selected bytes instead of counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timer <= '0;
    else     r_timer <= w_timer_next;
  end

  // Compare register, byte-lane writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_compare <= '0;
    else if (w_compare_we) r_compare <= f_merge_bytes(r_compare, wdata, sel);
  end

  // Sticky match flag: a set in the same cycle as a clear takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_match <= 1'b0;
    else if (w_match_set) r_match <= 1'b1;
    else if (w_match_clr) r_match <= 1'b0;
  end

  // Data RAM with per-byte write enables; writes are blocked during reset.
  // NOTE: the array has no reset branch on purpose -- resetting a memory
  // would turn it into thousands of flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst && w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) r_ram[w_ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read mux (zero-latency read data).
  // ---------------------------------------------------------------------------

  // Select the word addressed this cycle; pre-write values are returned.
  // NOTE: rdata gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (w_is_mmio) begin
      case (w_reg_off)
        REG_LED:     rdata = {16'h0, r_led};
        REG_SWITCH:  rdata = {16'h0, r_sw_sync};
        REG_TIMER:   rdata = r_timer;
        REG_COMPARE: rdata = r_compare;
        REG_STATUS:  rdata = {31'h0, r_match};
        default:     rdata = '0;
      endcase
    end else if (w_is_ram) begin
      rdata = r_ram[w_ram_idx];
    end
  end

  assign led = r_led;
  assign irq = r_match;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: reset state, a table of directed
// single-cycle vectors, hand-written multi-cycle sequences for the timer,
// interrupt and reset corners, then randomized traffic against a byte-level
// behavioural model.
module tb_data_mem_responder;

  localparam logic [31:0] A_LED     = 32'hBFAF_0000;
  localparam logic [31:0] A_SWITCH  = 32'hBFAF_0004;
  localparam logic [31:0] A_TIMER   = 32'hBFAF_0008;
  localparam logic [31:0] A_COMPARE = 32'hBFAF_000C;
  localparam logic [31:0] A_STATUS  = 32'hBFAF_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;

  data_mem_responder #(.RAM_AW(10), .MMIO_BASE(16'hBFAF)) dut (
    .clk      (clk),
    .rst      (rst),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .sel      (sel),
    .rdata    (rdata),
    .sw       (sw),
    .led      (led),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present one access and let the combinational read settle.
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    memwrite = we;
    addr     = a;
    wdata    = d;
    sel      = s;
    #1;
  endtask

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: RAM as a sparse byte store, registers as plain values,
  // switch path as a two-entry delay queue.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_compare;
  logic        m_flag;
  logic [15:0] m_swq [$];

  function automatic void model_reset();
    m_led     = '0;
    m_timer   = '0;
    m_compare = '0;
    m_flag    = 1'b0;
    m_swq     = {16'h0, 16'h0};
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hBFAF;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return !is_mmio(a) && (a < 32'd4096);
  endfunction

  function automatic int reg_index(input logic [31:0] a);
    return int'((a & 32'hFF) >> 2);
  endfunction

  function automatic logic [31:0] apply_lanes(input logic [31:0] v, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    int base;
    if (!is_ram(a)) return 1'b1;
    base = int'(a) & ~3;
    for (int i = 0; i < 4; i++) if (!m_ram.exists(base + i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int base;
    if (is_mmio(a)) begin
      case (reg_index(a))
        0:       return {16'h0, m_led};
        1:       return {16'h0, m_swq[0]};
        2:       return m_timer;
        3:       return m_compare;
        4:       return {31'h0, m_flag};
        default: return 32'h0;
      endcase
    end
    if (is_ram(a)) begin
      base = int'(a) & ~3;
      return {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
    end
    return 32'h0;
  endfunction

  // Everything that happens at one rising edge, given this cycle's inputs.
  function automatic void model_edge(input logic we, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] s,
                                     input logic [15:0] sw_now);
    logic [31:0] t_new;
    bit          wr_reg;
    int          base;
    wr_reg = we && is_mmio(a);
    t_new  = m_timer + 32'd1;
    if (wr_reg && reg_index(a) == 2) t_new = apply_lanes(m_timer, d, s);
    if (t_new == m_compare && m_compare != 0) m_flag = 1'b1;
    else if (wr_reg && reg_index(a) == 4 && s[0] && d[0]) m_flag = 1'b0;
    m_timer = t_new;
    if (wr_reg && reg_index(a) == 0) begin
      logic [31:0] l;
      l = apply_lanes({16'h0, m_led}, d, s);
      m_led = l[15:0];
    end
    if (wr_reg && reg_index(a) == 3) m_compare = apply_lanes(m_compare, d, s);
    if (we && is_ram(a)) begin
      base = int'(a) & ~3;
      for (int i = 0; i < 4; i++) if (s[i]) m_ram[base + i] = d[8*i +: 8];
    end
    m_swq.push_back(sw_now);
    void'(m_swq.pop_front());
  endfunction

  // One modelled cycle: drive, compare against the model, advance both.
  task automatic run_cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    drive(we, a, d, s);
    if (model_known(a)) check($sformatf("rand_rdata@%h", a), rdata, model_read(a));
    check("rand_irq", {31'h0, irq}, {31'h0, m_flag});
    check("rand_led", {16'h0, led}, {16'h0, m_led});
    model_edge(we, a, d, s, sw);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed single-cycle vectors: expected rdata is the value seen during the
  // cycle (before that cycle's write commits); expected led likewise.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit chk, input logic [31:0] exp_rd,
                              input logic [15:0] exp_led);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.s = s;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_led = exp_led;
    return v;
  endfunction

  vec_t tbl [$];

  logic        r_we;
  logic [31:0] r_a;
  logic [31:0] r_d;
  logic [3:0]  r_s;

  initial begin
    tbl.push_back(mk(1, 32'h10, 32'h1122_3344, 4'hF, 0, 32'h0,         16'h0));
    tbl.push_back(mk(1, 32'h10, 32'hAA00_0000, 4'h8, 1, 32'h1122_3344, 16'h0));
    tbl.push_back(mk(0, 32'h10, 32'h0,         4'h0, 1, 32'hAA22_3344, 16'h0));
    tbl.push_back(mk(0, 32'h13, 32'h0,         4'h0, 1, 32'hAA22_3344, 16'h0));
    tbl.push_back(mk(1, 32'h20, 32'h0,         4'hF, 0, 32'h0,         16'h0));
    tbl.push_back(mk(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         16'h0));
    tbl.push_back(mk(0, 32'h20, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 16'h0));
    tbl.push_back(mk(1, 32'h00, 32'h1234_5678, 4'hF, 0, 32'h0,         16'h0));
    tbl.push_back(mk(1, 32'h1000, 32'h5,       4'hF, 1, 32'h0,         16'h0));
    tbl.push_back(mk(0, 32'h1000, 32'h0,       4'h0, 1, 32'h0,         16'h0));
    tbl.push_back(mk(0, 32'h00, 32'h0,         4'h0, 1, 32'h1234_5678, 16'h0));
    tbl.push_back(mk(0, 32'h8000_0000, 32'h0,  4'h0, 1, 32'h0,         16'h0));
    tbl.push_back(mk(1, A_LED, 32'h0001_A5A5,  4'hF, 1, 32'h0,         16'h0));
    tbl.push_back(mk(0, A_LED, 32'h0,          4'h0, 1, 32'h0000_A5A5, 16'hA5A5));
    tbl.push_back(mk(1, A_LED, 32'h0000_FF00,  4'h2, 1, 32'h0000_A5A5, 16'hA5A5));
    tbl.push_back(mk(0, A_LED, 32'h0,          4'h0, 1, 32'h0000_FFA5, 16'hFFA5));
    tbl.push_back(mk(0, 32'hBFAF_0040, 32'h0,  4'h0, 1, 32'h0,         16'hFFA5));
    tbl.push_back(mk(1, A_SWITCH, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,       16'hFFA5));
    tbl.push_back(mk(0, A_SWITCH, 32'h0,       4'h0, 1, 32'h0,         16'hFFA5));

    // Reset state, checked while rst is held.
    rst = 1'b1; memwrite = 1'b0; addr = '0; wdata = '0; sel = '0; sw = '0;
    #2;
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    drive(0, A_TIMER, 0, 0);
    check("reset_timer_rd", rdata, 32'h0);
    drive(0, A_STATUS, 0, 0);
    check("reset_status_rd", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    drive(0, A_TIMER, 0, 0);
    check("timer_first_count", rdata, 32'h1);
    step();

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s);
      if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      step();
    end

    // Switch path: a change is visible two edges later.
    drive(0, A_SWITCH, 0, 0);
    sw = 16'h5A5A;
    #1;
    check("sw_lat0", rdata, 32'h0);
    step();
    check("sw_lat1", rdata, 32'h0);
    step();
    check("sw_lat2", rdata, 32'h0000_5A5A);

    // COMPARE=10 then TIMER=5: the flag (and irq) come up on the 5th edge
    // after the timer write edge, i.e. in the 6th cycle counting the one
    // that follows the write edge as the first.
    drive(1, A_COMPARE, 32'd10, 4'hF); step();
    drive(1, A_TIMER, 32'd5, 4'hF);    step();
    for (int k = 0; k <= 6; k++) begin
      drive(0, A_TIMER, 0, 0);
      check($sformatf("cmp_timer_k%0d", k), rdata, 32'd5 + 32'(k));
      check($sformatf("cmp_irq_k%0d", k), {31'h0, irq}, (k >= 5) ? 32'h1 : 32'h0);
      step();
    end
    drive(0, A_STATUS, 0, 0);
    check("status_set_rd", rdata, 32'h1);
    // Writing 1 to bit0 without sel[0] must not clear.
    drive(1, A_STATUS, 32'h1, 4'h2); step();
    check("status_nosel_irq", {31'h0, irq}, 32'h1);
    drive(1, A_STATUS, 32'h1, 4'h1); step();
    check("status_clr_irq", {31'h0, irq}, 32'h0);
    drive(0, A_STATUS, 0, 0);
    check("status_clr_rd", rdata, 32'h0);

    // COMPARE=0 disables matching, even across the timer wrap.
    drive(1, A_COMPARE, 32'h0, 4'hF);        step();
    drive(1, A_TIMER, 32'hFFFF_FFFE, 4'hF);  step();
    for (int k = 0; k < 4; k++) begin
      drive(0, A_TIMER, 0, 0);
      check($sformatf("wrap_timer_k%0d", k), rdata, 32'hFFFF_FFFE + 32'(k));
      check($sformatf("wrap_irq_k%0d", k), {31'h0, irq}, 32'h0);
      step();
    end

    // Set/clear collision: clear presented in the cycle whose edge sets.
    drive(1, A_COMPARE, 32'd20, 4'hF); step();
    drive(1, A_TIMER, 32'd15, 4'hF);   step();
    for (int k = 1; k <= 4; k++) begin
      drive(0, A_TIMER, 0, 0);
      step();
    end
    drive(1, A_STATUS, 32'h1, 4'h1);
    check("collide_pre_irq", {31'h0, irq}, 32'h0);
    step();
    check("collide_irq", {31'h0, irq}, 32'h1);
    drive(0, A_STATUS, 0, 0);
    check("collide_status_rd", rdata, 32'h1);

    // Asynchronous reset between edges, with a RAM write held across an edge.
    drive(1, A_LED, 32'h0000_FFFF, 4'h3); step();
    check("pre_rst_led", {16'h0, led}, 32'h0000_FFFF);
    drive(0, A_TIMER, 0, 0);
    check("pre_rst_timer_nz", {31'h0, rdata != 32'h0}, 32'h1);
    rst = 1'b1;
    #1;
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    check("arst_timer_rd", rdata, 32'h0);
    drive(0, A_LED, 0, 0);
    check("arst_led_rd", rdata, 32'h0);
    drive(1, 32'h10, 32'h0, 4'hF);
    step();
    drive(0, 32'h10, 0, 0);
    check("arst_ram_kept", rdata, 32'hAA22_3344);
    rst = 1'b0;
    step();
    check("post_rst_ram", rdata, 32'hAA22_3344);

    // Randomized traffic against the model.
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int w = 0; w < 64; w++) run_cycle(1, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    r_a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        2:       r_a = {16'hBFAF, 8'($urandom), 6'($urandom_range(0, 7)), 2'($urandom)};
        default: r_a = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 32'hEFFF))
                                                   : {16'h0001 + 16'($urandom_range(0, 100)),
                                                      16'($urandom)};
      endcase
      r_we = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      r_s  = 4'($urandom);
      if (is_mmio(r_a) && r_we) begin
        if (reg_index(r_a) == 2 && $urandom_range(0, 3) != 0) begin
          r_d = m_compare - 32'($urandom_range(1, 6));
          r_s = 4'hF;
        end else if (reg_index(r_a) == 3) begin
          r_d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        end
      end
      run_cycle(r_we, r_a, r_d, r_s);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_arst_led", {16'h0, led}, 32'h0);
        check("rand_arst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
